vga_plot_arbiter: RTL and testbench

//   Shares the single pixel-write port of the VGA frame-buffer adapter (x, y, colour, plot)

---
 rtl/vga_plot_arbiter.sv | 142 ++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin, burst-locked arbiter sharing the VGA adapter's single pixel-write port among
// NUM_REQ draw engines. Optional macro PLOT_CLIP_EN suppresses the plot strobe for off-screen beats.
module vga_plot_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int X_W       = 8,
   parameter int Y_W       = 8,
   parameter int COLOUR_W  = 3,
   parameter int MAX_BURST = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ-1:0]           last,
   input  logic [NUM_REQ*X_W-1:0]       px_x,
   input  logic [NUM_REQ*Y_W-1:0]       px_y,
   input  logic [NUM_REQ*COLOUR_W-1:0]  px_colour,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [X_W-1:0]               vga_x,
   output logic [Y_W-1:0]               vga_y,
   output logic [COLOUR_W-1:0]          vga_colour,
   output logic                         vga_plot,
   output logic                         busy,
   output logic                         abort
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BURST);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t               state_q;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [IDX_W-1:0]     owner_q;
   logic [CNT_W-1:0]     beat_cnt_q;
   logic [NUM_REQ-1:0]   gnt_q;
   logic [X_W-1:0]       vga_x_q;
   logic [Y_W-1:0]       vga_y_q;
   logic [COLOUR_W-1:0]  vga_colour_q;
   logic                 vga_plot_q;
   logic                 busy_q;
   logic                 abort_q;

   logic                 win_found;
   logic [IDX_W-1:0]     win_idx;
   logic [IDX_W-1:0]     cand;
   logic [IDX_W-1:0]     next_ptr;
   logic                 beat;
   logic                 owner_last;
   logic                 wd_hit;
   logic                 on_screen;
   logic [X_W-1:0]       cur_x;
   logic [Y_W-1:0]       cur_y;
   logic [COLOUR_W-1:0]  cur_colour;

   // First requester at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign cur_x      = px_x[int'(owner_q)*X_W +: X_W];
   assign cur_y      = px_y[int'(owner_q)*Y_W +: Y_W];
   assign cur_colour = px_colour[int'(owner_q)*COLOUR_W +: COLOUR_W];
   assign beat       = (state_q == LOCK) && req[owner_q];
   assign owner_last = last[owner_q];
   assign wd_hit     = (beat_cnt_q == CNT_W'(MAX_BURST - 1));
   assign next_ptr   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

`ifdef PLOT_CLIP_EN
   // Screen is 160x120; beats outside it are consumed without a write strobe.
   assign on_screen = (32'(cur_x) < 32'd160) && (32'(cur_y) < 32'd120);
`else
   assign on_screen = 1'b1;
`endif

   // NOTE: sequential state uses non-blocking assignments only, so every register in this
   // block sees the pre-edge value of every other register regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         beat_cnt_q   <= '0;
         gnt_q        <= '0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
         busy_q       <= 1'b0;
         abort_q      <= 1'b0;
      end else begin
         vga_plot_q <= 1'b0;
         abort_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (win_found) begin
                  owner_q    <= win_idx;
                  gnt_q      <= NUM_REQ'(1) << win_idx;
                  beat_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= LOCK;
               end
            end
            LOCK: begin
               if (beat) begin
                  vga_x_q      <= cur_x;
                  vga_y_q      <= cur_y;
                  vga_colour_q <= cur_colour;
                  vga_plot_q   <= on_screen;
                  beat_cnt_q   <= beat_cnt_q + CNT_W'(1);
                  // Watchdog release behaves like last, but flags the truncated burst.
                  if (owner_last || wd_hit) begin
                     gnt_q    <= '0;
                     rr_ptr_q <= next_ptr;
                     busy_q   <= 1'b0;
                     abort_q  <= !owner_last;
                     state_q  <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt        = gnt_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_colour = vga_colour_q;
   assign vga_plot   = vga_plot_q;
   assign busy       = busy_q;
   assign abort      = abort_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter: directed scenarios plus randomized engine traffic,
// scored against a transaction-level model of the arbitration rules.
module tb_vga_plot_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int X_W       = 8;
   localparam int Y_W       = 8;
   localparam int COLOUR_W  = 3;
   localparam int MAX_BURST = 64;

   typedef struct packed {
      logic [X_W-1:0]      x;
      logic [Y_W-1:0]      y;
      logic [COLOUR_W-1:0] col;
      logic                lst;
   } pix_t;

   logic                         clk = 1'b0;
   logic                         rst = 1'b0;
   logic [NUM_REQ-1:0]           req = '0;
   logic [NUM_REQ-1:0]           last = '0;
   logic [NUM_REQ*X_W-1:0]       px_x = '0;
   logic [NUM_REQ*Y_W-1:0]       px_y = '0;
   logic [NUM_REQ*COLOUR_W-1:0]  px_colour = '0;
   logic [NUM_REQ-1:0]           gnt;
   logic [X_W-1:0]               vga_x;
   logic [Y_W-1:0]               vga_y;
   logic [COLOUR_W-1:0]          vga_colour;
   logic                         vga_plot;
   logic                         busy;
   logic                         abort;

   vga_plot_arbiter #(
      .NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .last(last),
      .px_x(px_x), .px_y(px_y), .px_colour(px_colour),
      .gnt(gnt), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
      .vga_plot(vga_plot), .busy(busy), .abort(abort)
   );

   always #5 clk = ~clk;

   // Engine stimulus: each engine drains a queue of pixels; hold forces a stall.
   pix_t eng_q [NUM_REQ][$];
   logic hold [NUM_REQ];

   // Reference model: owner index (-1 when idle), pointer, beats in current burst.
   int                  m_owner = -1;
   int                  m_ptr   = 0;
   int                  m_cnt   = 0;
   int                  beat_eng;
   logic [NUM_REQ-1:0]  e_gnt = '0;
   logic [X_W-1:0]      e_x = '0;
   logic [Y_W-1:0]      e_y = '0;
   logic [COLOUR_W-1:0] e_col = '0;
   logic                e_plot = 1'b0;
   logic                e_busy = 1'b0;
   logic                e_abort = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int grant_log[$];
   logic [NUM_REQ-1:0] prev_gnt = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic visible(input pix_t p);
`ifdef PLOT_CLIP_EN
      return (int'(p.x) < 160) && (int'(p.y) < 120);
`else
      return 1'b1;
`endif
   endfunction

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         if (eng_q[i].size() > 0) begin
            req[i]                          = !hold[i];
            last[i]                         = eng_q[i][0].lst;
            px_x[i*X_W +: X_W]              = eng_q[i][0].x;
            px_y[i*Y_W +: Y_W]              = eng_q[i][0].y;
            px_colour[i*COLOUR_W +: COLOUR_W] = eng_q[i][0].col;
         end else begin
            req[i]  = 1'b0;
            last[i] = 1'b0;
         end
      end
   endtask

   task automatic model_step();
      pix_t p;
      bit   found;
      beat_eng = -1;
      e_plot   = 1'b0;
      e_abort  = 1'b0;
      found    = 1'b0;
      if (!rst) begin
         m_owner = -1; m_ptr = 0; m_cnt = 0;
         e_x = '0; e_y = '0; e_col = '0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            int j;
            j = (m_ptr + k) % NUM_REQ;
            if (!found && req[j]) begin
               found   = 1'b1;
               m_owner = j;
               m_cnt   = 0;
            end
         end
      end else if (req[m_owner]) begin
         beat_eng = m_owner;
         p        = eng_q[m_owner][0];
         e_x      = p.x;
         e_y      = p.y;
         e_col    = p.col;
         e_plot   = visible(p);
         m_cnt++;
         if (p.lst || m_cnt == MAX_BURST) begin
            e_abort = !p.lst;
            m_ptr   = (m_owner + 1) % NUM_REQ;
            m_owner = -1;
         end
      end
      e_gnt  = (m_owner < 0) ? '0 : NUM_REQ'(1) << m_owner;
      e_busy = (m_owner >= 0);
   endtask

   // One clock: inputs applied on the falling edge, outputs checked on the next falling edge.
   task automatic tick();
      drive();
      model_step();
      @(posedge clk);
      @(negedge clk);
      if (beat_eng >= 0) void'(eng_q[beat_eng].pop_front());
      check("gnt", 32'(gnt), 32'(e_gnt));
      check("vga_plot", 32'(vga_plot), 32'(e_plot));
      check("busy", 32'(busy), 32'(e_busy));
      check("abort", 32'(abort), 32'(e_abort));
      if (e_plot || !rst) begin
         check("vga_x", 32'(vga_x), 32'(e_x));
         check("vga_y", 32'(vga_y), 32'(e_y));
         check("vga_colour", 32'(vga_colour), 32'(e_col));
      end
      if (gnt != '0 && prev_gnt == '0) begin
         for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) grant_log.push_back(i);
      end
      prev_gnt = gnt;
   endtask

   task automatic clear_engines();
      for (int i = 0; i < NUM_REQ; i++) begin
         eng_q[i].delete();
         hold[i] = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b0;
      clear_engines();
      repeat (n) tick();
      rst = 1'b1;
   endtask

   task automatic push_pix(input int e, input int x, input int y, input int col, input bit lst);
      pix_t p;
      p.x = X_W'(x); p.y = Y_W'(y); p.col = COLOUR_W'(col); p.lst = lst;
      eng_q[e].push_back(p);
   endtask

   initial begin
      int plots, exp_y, guard, aborts, gnt_after_abort;
      bit seen_abort;

      // Reset held with every engine requesting: all outputs stay zero.
      clear_engines();
      for (int i = 0; i < NUM_REQ; i++) push_pix(i, 5, 5, 1, 1'b1);
      rst = 1'b0;
      repeat (3) begin
         tick();
         check("rst_gnt", 32'(gnt), 32'd0);
         check("rst_plot", 32'(vga_plot), 32'd0);
      end
      clear_engines();
      rst = 1'b1;

      // Single 16-beat burst from engine 1.
      for (int k = 0; k < 16; k++) push_pix(1, 10, 52 + k, k % 8, k == 15);
      tick();
      check("single_first_gnt", 32'(gnt), 32'b0010);
      plots = 0; exp_y = 52; guard = 0;
      while ((eng_q[1].size() > 0 || busy) && guard < 40) begin
         tick();
         guard++;
         if (vga_plot) begin
            check("single_y_seq", 32'(vga_y), 32'(exp_y));
            exp_y++;
            plots++;
         end
      end
      check("single_timeout", 32'(guard < 40), 32'd1);
      check("single_plot_count", 32'(plots), 32'd16);
      tick();
      check("single_idle_gnt", 32'(gnt), 32'd0);

      // Round-robin with continuous single-beat requests from all engines.
      do_reset(2);
      grant_log.delete();
      guard = 0;
      while (grant_log.size() < 5 && guard < 40) begin
         for (int i = 0; i < NUM_REQ; i++) if (eng_q[i].size() == 0) push_pix(i, i, i, i, 1'b1);
         tick();
         guard++;
      end
      check("rr_timeout", 32'(guard < 40), 32'd1);
      check("rr_grant0", 32'(grant_log.size() > 0 ? grant_log[0] : -1), 32'd0);
      check("rr_grant1", 32'(grant_log.size() > 1 ? grant_log[1] : -1), 32'd1);
      check("rr_grant2", 32'(grant_log.size() > 2 ? grant_log[2] : -1), 32'd2);
      check("rr_grant3", 32'(grant_log.size() > 3 ? grant_log[3] : -1), 32'd3);
      check("rr_grant4", 32'(grant_log.size() > 4 ? grant_log[4] : -1), 32'd0);

      // Stall: owner drops req for three cycles mid-burst.
      do_reset(2);
      for (int k = 0; k < 6; k++) push_pix(0, 20, k, 2, k == 5);
      plots = 0; exp_y = 0; guard = 0;
      while (eng_q[0].size() > 4 && guard < 20) begin
         tick();
         guard++;
         if (vga_plot) begin check("stall_y_seq", 32'(vga_y), 32'(exp_y)); exp_y++; plots++; end
      end
      hold[0] = 1'b1;
      repeat (3) begin
         tick();
         if (vga_plot) plots++;
         check("stall_gnt_held", 32'(gnt), 32'b0001);
      end
      hold[0] = 1'b0;
      while ((eng_q[0].size() > 0 || busy) && guard < 40) begin
         tick();
         guard++;
         if (vga_plot) begin check("stall_y_seq", 32'(vga_y), 32'(exp_y)); exp_y++; plots++; end
      end
      check("stall_timeout", 32'(guard < 40), 32'd1);
      check("stall_plot_count", 32'(plots), 32'd6);

      // Watchdog: engine 2 never flags last; engine 3 waits with a single beat.
      do_reset(2);
      for (int k = 0; k < 70; k++) push_pix(2, k, 7, 4, 1'b0);
      push_pix(3, 99, 99, 5, 1'b1);
      plots = 0; aborts = 0; seen_abort = 0; gnt_after_abort = -1; guard = 0;
      while (eng_q[3].size() > 0 && guard < 200) begin
         tick();
         guard++;
         if (vga_plot && !seen_abort) plots++;
         if (abort) begin aborts++; seen_abort = 1; end
         else if (seen_abort && gnt != '0 && gnt_after_abort < 0) gnt_after_abort = int'(gnt);
      end
      check("wd_timeout", 32'(guard < 200), 32'd1);
      check("wd_plot_count", 32'(plots), 32'd64);
      check("wd_abort_cycles", 32'(aborts), 32'd1);
      check("wd_next_grant", 32'(gnt_after_abort), 32'b1000);

      // Clipping boundary beats.
      do_reset(2);
      push_pix(0, 159, 119, 7, 1'b0);
      push_pix(0, 160, 60, 7, 1'b0);
      push_pix(0, 80, 120, 7, 1'b1);
      plots = 0; guard = 0;
      while ((eng_q[0].size() > 0 || busy) && guard < 20) begin
         tick();
         guard++;
         if (vga_plot) plots++;
      end
      tick();
      if (vga_plot) plots++;
`ifdef PLOT_CLIP_EN
      check("clip_plot_count", 32'(plots), 32'd1);
`else
      check("clip_plot_count", 32'(plots), 32'd3);
`endif

      // Randomized traffic with stalls and one reset mid-run.
      do_reset(2);
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (eng_q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               int len;
               len = $urandom_range(1, 12);
               for (int k = 0; k < len; k++)
                  push_pix(i, $urandom_range(0, 255), $urandom_range(0, 255),
                           $urandom_range(0, 7), k == len - 1);
            end
            hold[i] = ($urandom_range(0, 4) == 0);
         end
         if (c == 300) begin
            rst = 1'b0;
            tick();
            clear_engines();
            rst = 1'b1;
         end else begin
            tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
